cachereplace: RTL and testbench

Parametrised victim-way selector for the set-associative L1 caches, superseding the fixed random selector. Runtime-selectable policy: LFSR pseudo-random or per-set round-robin. Invalid ways are always preferred. Software-controlled way locking excludes ways from eviction. Sits beside the tag/valid arrays in the cache and feeds `VictimWay` to the way-select and fill logic.

---
 rtl/cachereplace.sv | 66 ++++++
 tb/tb_cachereplace.sv | 106 ++++++++++
 2 files changed

// File: rtl/cachereplace.sv
// cachereplace: victim-way selector with invalid-first, way locking and LFSR or per-set round-robin policy.
// Victim outputs are combinational from the registered LFSR/pointers and the current lookup inputs.
module cachereplace #(
  parameter int NUMWAYS = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN = $clog2(NUMLINES),
  parameter int LFSRLEN = 16,
  parameter logic [LFSRLEN-1:0] SEED = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_stage_i,
  input  logic                       cache_en_i,
  input  logic                       mode_i,
  input  logic [SETLEN-1:0]          cache_set_i,
  input  logic [NUMWAYS-1:0]         valid_way_i,
  input  logic [NUMWAYS-1:0]         lock_way_i,
  input  logic                       lru_write_en_i,
  input  logic                       invalidate_cache_i,
  output logic [NUMWAYS-1:0]         victim_way_o,
  output logic [$clog2(NUMWAYS)-1:0] victim_way_enc_o
);
  localparam int WL = $clog2(NUMWAYS);
  logic [LFSRLEN-1:0] lfsr_q, lfsr_d;
  logic [WL-1:0] ptr_q [NUMLINES];
  logic [WL-1:0] ptr_d, start, idx;
  logic [NUMWAYS-1:0] elig, inv;
  logic found, ptr_we;
  always_comb begin
    elig = &lock_way_i ? '1 : ~lock_way_i;
    inv = elig & ~valid_way_i;
    start = mode_i ? ptr_q[cache_set_i] : lfsr_q[WL-1:0];
    victim_way_enc_o = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUMWAYS; k++)
      if (!found && inv[k]) begin
        victim_way_enc_o = WL'(k);
        found = 1'b1;
      end
    // no invalid eligible way: rotate from the policy start index
    for (int k = 0; k < NUMWAYS; k++) begin
      idx = start + WL'(k);
      if (!found && elig[idx]) begin
        victim_way_enc_o = idx;
        found = 1'b1;
      end
    end
  end
  assign victim_way_o = {{(NUMWAYS-1){1'b0}}, 1'b1} << victim_way_enc_o;
  assign lfsr_d = (cache_en_i && !flush_stage_i)
                ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSRLEN-1:1]}
                : lfsr_q;
  assign ptr_we = lru_write_en_i && !flush_stage_i && mode_i;
  assign ptr_d = victim_way_enc_o + 1'b1;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)
      for (int i = 0; i < NUMLINES; i++) ptr_q[i] <= '0;
    else if (invalidate_cache_i)
      for (int i = 0; i < NUMLINES; i++) ptr_q[i] <= '0;
    else if (ptr_we)
      ptr_q[cache_set_i] <= ptr_d;
endmodule

// File: tb/tb_cachereplace.sv
// tb_cachereplace: table-driven and sequence checks of cachereplace with an expected-result queue.
module tb_cachereplace;
  logic clk = 0, reset_n = 0, flush = 0, en = 0, mode = 0, we = 0, inv = 0;
  logic [6:0] set = '0;
  logic [3:0] valid = '0, lock = '0, vway;
  logic [1:0] venc;
  int checks = 0, errors = 0;
  typedef struct { string nm; logic [3:0] way; } exp_t;
  exp_t sb[$];
  typedef struct { logic m; logic [3:0] v; logic [3:0] l; logic [6:0] s; logic [3:0] w; } vec_t;
  vec_t vt[11];

  cachereplace dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_stage_i(flush), .cache_en_i(en), .mode_i(mode),
    .cache_set_i(set), .valid_way_i(valid), .lock_way_i(lock), .lru_write_en_i(we),
    .invalidate_cache_i(inv), .victim_way_o(vway), .victim_way_enc_o(venc)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc_of(input logic [3:0] w);
    return w[3] ? 2'd3 : w[2] ? 2'd2 : w[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic m, input logic [3:0] v, input logic [3:0] l, input logic [6:0] s,
                       input logic w, input logic iv, input logic fl, input logic e,
                       input logic [3:0] ew, input string nm);
    @(posedge clk); #1;
    mode = m; valid = v; lock = l; set = s; we = w; inv = iv; flush = fl; en = e;
    sb.push_back('{nm, ew});
    @(negedge clk);
    begin
      exp_t x;
      x = sb.pop_front();
      chk({x.nm, "_way"}, {28'd0, vway}, {28'd0, x.way});
      chk({x.nm, "_enc"}, {30'd0, venc}, {30'd0, enc_of(x.way)});
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // lfsr held at ACE1 (start index 1), all pointers 0
    vt[0]  = '{1'b0, 4'b0000, 4'b0000, 7'd0, 4'b0001};
    vt[1]  = '{1'b0, 4'b1011, 4'b0000, 7'd0, 4'b0100};
    vt[2]  = '{1'b1, 4'b1011, 4'b0000, 7'd5, 4'b0100};
    vt[3]  = '{1'b0, 4'b1111, 4'b0000, 7'd0, 4'b0010};
    vt[4]  = '{1'b0, 4'b1111, 4'b0110, 7'd0, 4'b1000};
    vt[5]  = '{1'b0, 4'b1111, 4'b1111, 7'd0, 4'b0010};
    vt[6]  = '{1'b1, 4'b1111, 4'b0000, 7'd5, 4'b0001};
    vt[7]  = '{1'b1, 4'b1111, 4'b0001, 7'd5, 4'b0010};
    vt[8]  = '{1'b0, 4'b0000, 4'b0001, 7'd0, 4'b0010};
    vt[9]  = '{1'b0, 4'b1110, 4'b0011, 7'd0, 4'b0100};
    vt[10] = '{1'b0, 4'b0111, 4'b1111, 7'd0, 4'b1000};
    #12 reset_n = 1;
    chk("reset_lfsr", {16'd0, dut.lfsr_q}, 32'hACE1);
    for (int i = 0; i < 11; i++)
      apply(vt[i].m, vt[i].v, vt[i].l, vt[i].s, 0, 0, 0, 0, vt[i].w, $sformatf("vec%0d", i));
    apply(0, 4'hF, 0, 0, 0, 0, 0, 1, 4'b0010, "lfsr0");
    apply(0, 4'hF, 0, 0, 0, 0, 1, 1, 4'b0001, "lfsr1");
    chk("lfsr_5670", {16'd0, dut.lfsr_q}, 32'h5670);
    apply(0, 4'hF, 0, 0, 0, 0, 0, 1, 4'b0001, "lfsr_flush");
    chk("lfsr_flush_hold", {16'd0, dut.lfsr_q}, 32'h5670);
    apply(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'b0001, "lfsr2");
    chk("lfsr_ab38", {16'd0, dut.lfsr_q}, 32'hAB38);
    for (int k = 0; k < 4; k++)
      apply(1, 4'hF, 0, 7'd5, 1, 0, 0, 0, 4'b0001 << k, $sformatf("rr%0d", k));
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0001, "rr_wrap");
    apply(1, 4'hF, 0, 7'd6, 0, 0, 0, 0, 4'b0001, "rr_set6");
    for (int k = 0; k < 3; k++)
      apply(1, 4'hF, 0, 7'd5, 1, 0, 0, 0, 4'b0001 << k, $sformatf("rr_again%0d", k));
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b1000, "rr_ptr3");
    apply(1, 4'hF, 4'b1000, 7'd5, 1, 0, 0, 0, 4'b0001, "rr_lock_wrap");
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0010, "rr_ptr1");
    chk("ptr5_is1", {30'd0, dut.ptr_q[5]}, 32'd1);
    apply(1, 4'hF, 0, 7'd5, 1, 0, 1, 0, 4'b0010, "rr_flush_we");
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0010, "rr_flush_hold");
    apply(1, 4'hF, 0, 7'd5, 1, 1, 0, 0, 4'b0010, "rr_inv_we");
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0001, "rr_inv_clear");
    chk("ptr5_inv", {30'd0, dut.ptr_q[5]}, 32'd0);
    apply(1, 4'hF, 0, 7'd5, 1, 0, 0, 1, 4'b0001, "pre_reset_we");
    apply(1, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0010, "pre_reset");
    chk("lfsr_559c", {16'd0, dut.lfsr_q}, 32'h559C);
    #1 reset_n = 0;
    #1;
    chk("async_lfsr", {16'd0, dut.lfsr_q}, 32'hACE1);
    chk("async_ptr5", {30'd0, dut.ptr_q[5]}, 32'd0);
    chk("async_way", {28'd0, vway}, 32'b0001);
    #1 reset_n = 1;
    apply(0, 4'hF, 0, 7'd5, 0, 0, 0, 0, 4'b0010, "post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
